// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and defaults for the operand/result RAM port arbiter.
package ram_port_arbiter_pkg;

    typedef enum logic {
        HOST = 1'b0,
        ENG  = 1'b1
    } owner_t;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int ADDR_W_DEF   = 4;
    localparam int DATA_W_DEF   = 16;
    localparam int MAX_LOCK_DEF = 4;

    // Plain 2-way round-robin pick. req/gnt bit 0 is the host, bit 1 the engine.
    // With both requesting, the port that did not own the last slot wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input owner_t last);
        logic [1:0] g;
        g = req;
        if (req == 2'b11) begin
            g = (last == HOST) ? 2'b10 : 2'b01;
        end
        return g;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arb2_lock.sv
// Combinational round-robin arbiter with engine lock and starvation cap.
// Produces this cycle's grant plus the next arbiter state, owner and lock count.
module rr_arb2_lock
    import ram_port_arbiter_pkg::*;
#(
    parameter int MAX_LOCK = MAX_LOCK_DEF,
    parameter int CNT_W    = $clog2(MAX_LOCK + 1)
) (
    input  logic [1:0]       req_i,
    input  logic             lock_i,
    input  arb_state_t       state_i,
    input  owner_t           last_owner_i,
    input  logic [CNT_W-1:0] lock_cnt_i,
    output logic [1:0]       gnt_o,
    output arb_state_t       state_o,
    output owner_t           last_owner_o,
    output logic [CNT_W-1:0] lock_cnt_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

    logic   eng_holds;
    owner_t rr_last;

    // Engine keeps the slot only while it is locked and still requesting.
    assign eng_holds = (state_i == LOCKED) && req_i[1] && lock_i;
    // Leaving LOCKED arbitrates with the engine treated as the last owner.
    assign rr_last   = (state_i == LOCKED) ? ENG : last_owner_i;

    // Grant selection and next-state computation.
    always_comb begin
        gnt_o        = 2'b00;
        state_o      = state_i;
        lock_cnt_o   = lock_cnt_i;
        last_owner_o = last_owner_i;

        if (!eng_holds) begin
            gnt_o = rr_pick(req_i, rr_last);
            if (gnt_o[1] && lock_i) begin
                state_o    = LOCKED;
                lock_cnt_o = CNT_W'(1);
            end else begin
                state_o    = ARB;
                lock_cnt_o = '0;
            end
        end else if (lock_cnt_i < MAX_CNT) begin
            gnt_o      = 2'b10;
            lock_cnt_o = lock_cnt_i + CNT_W'(1);
        end else if (req_i[0]) begin
            // Cap reached and the host is waiting: it gets exactly one slot.
            gnt_o      = 2'b01;
            state_o    = ARB;
            lock_cnt_o = '0;
        end else begin
            // Cap reached but nobody else wants the RAM; count saturates.
            gnt_o = 2'b10;
        end

        if (gnt_o[0]) begin
            last_owner_o = HOST;
        end else if (gnt_o[1]) begin
            last_owner_o = ENG;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single-port operand/result RAM between the host and the compute
// engine: one access per cycle, round-robin with engine lock, and a one-cycle
// read-return path tagged with the owning port.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    input  logic              e_req,
    input  logic              e_we,
    input  logic [ADDR_W-1:0] e_addr,
    input  logic [DATA_W-1:0] e_wdata,
    input  logic              e_lock,
    output logic              e_gnt,
    output logic              e_rvalid,
    output logic [DATA_W-1:0] e_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    arb_state_t       state_q, state_d;
    owner_t           last_owner_q, last_owner_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             rd_pend_q, rd_pend_d;
    owner_t           rd_owner_q, rd_owner_d;
    logic [1:0]       gnt_raw;
    logic [1:0]       gnt;

    rr_arb2_lock #(
        .MAX_LOCK (MAX_LOCK),
        .CNT_W    (CNT_W)
    ) u_arb (
        .req_i        ({e_req, h_req}),
        .lock_i       (e_lock),
        .state_i      (state_q),
        .last_owner_i (last_owner_q),
        .lock_cnt_i   (lock_cnt_q),
        .gnt_o        (gnt_raw),
        .state_o      (state_d),
        .last_owner_o (last_owner_d),
        .lock_cnt_o   (lock_cnt_d)
    );

    // Grants are combinational, so they are masked while reset is held.
    assign gnt   = gnt_raw & {2{rst}};
    assign h_gnt = gnt[0];
    assign e_gnt = gnt[1];

    // RAM command mux: the granted port drives the RAM, otherwise all zero.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (gnt[0]) begin
            ram_en    = 1'b1;
            ram_we    = h_we;
            ram_addr  = h_addr;
            ram_wdata = h_wdata;
        end else if (gnt[1]) begin
            ram_en    = 1'b1;
            ram_we    = e_we;
            ram_addr  = e_addr;
            ram_wdata = e_wdata;
        end
    end

    assign rd_pend_d  = ram_en & ~ram_we;
    assign rd_owner_d = gnt[1] ? ENG : HOST;

    // Arbiter state, owner history, lock count and read-return tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ARB;
            last_owner_q <= HOST;
            lock_cnt_q   <= '0;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= HOST;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            lock_cnt_q   <= lock_cnt_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    assign h_rvalid = rd_pend_q && (rd_owner_q == HOST);
    assign e_rvalid = rd_pend_q && (rd_owner_q == ENG);
    assign h_rdata  = h_rvalid ? ram_rdata : '0;
    assign e_rdata  = e_rvalid ? ram_rdata : '0;
    assign busy     = (state_q != ARB) || rd_pend_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a write-first synchronous RAM model.
module tb_ram_port_arbiter;

    localparam int G_N = 0;
    localparam int G_H = 1;
    localparam int G_E = 2;

    typedef struct {
        logic        eng;
        logic        we;
        logic [3:0]  addr;
        logic [15:0] wdata;
    } gexp_t;

    logic        clk;
    logic        rst;
    logic        h_req, h_we, h_gnt, h_rvalid;
    logic [3:0]  h_addr;
    logic [15:0] h_wdata, h_rdata;
    logic        e_req, e_we, e_lock, e_gnt, e_rvalid;
    logic [3:0]  e_addr;
    logic [15:0] e_wdata, e_rdata;
    logic        ram_en, ram_we, busy;
    logic [3:0]  ram_addr;
    logic [15:0] ram_wdata, ram_rdata;

    logic [15:0] mem [16];

    gexp_t       gq [$];
    logic [15:0] hq [$];
    logic [15:0] eq [$];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   ncyc    = 0;
    logic done      = 1'b0;
    logic chk_zero  = 1'b0;
    logic chk_busy  = 1'b0;
    logic exp_busy  = 1'b0;

    ram_port_arbiter #(
        .ADDR_W   (4),
        .DATA_W   (16),
        .MAX_LOCK (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .h_req     (h_req),
        .h_we      (h_we),
        .h_addr    (h_addr),
        .h_wdata   (h_wdata),
        .h_gnt     (h_gnt),
        .h_rvalid  (h_rvalid),
        .h_rdata   (h_rdata),
        .e_req     (e_req),
        .e_we      (e_we),
        .e_addr    (e_addr),
        .e_wdata   (e_wdata),
        .e_lock    (e_lock),
        .e_gnt     (e_gnt),
        .e_rvalid  (e_rvalid),
        .e_rdata   (e_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Write-first synchronous RAM behind the arbiter.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                ram_rdata     <= ram_wdata;
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a grant or read data.
    initial begin
        gexp_t       g;
        logic [58:0] zv;
        forever begin
            @(negedge clk);
            ncyc++;
            if (ncyc > 20000) begin
                n_tests++;
                n_fail++;
                $display("FAIL timeout: cycles %0d exceeded budget 20000", ncyc);
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $finish;
            end
            chk("ram_en_vs_gnt", ram_en, h_gnt | e_gnt);
            if (h_gnt || e_gnt) begin
                if (gq.size() == 0) begin
                    chk("gnt_unexpected", {h_gnt, e_gnt}, 2'b00);
                end else begin
                    g = gq.pop_front();
                    chk("gnt_owner", {h_gnt, e_gnt}, g.eng ? 2'b01 : 2'b10);
                    chk("ram_we", ram_we, g.we);
                    chk("ram_addr", ram_addr, g.addr);
                    chk("ram_wdata", ram_wdata, g.wdata);
                end
            end
            if (h_rvalid) begin
                if (hq.size() == 0) chk("h_rvalid_unexpected", h_rvalid, 1'b0);
                else                chk("h_rdata", h_rdata, hq.pop_front());
                chk("e_rdata_while_h", e_rdata, 16'h0);
            end
            if (e_rvalid) begin
                if (eq.size() == 0) chk("e_rvalid_unexpected", e_rvalid, 1'b0);
                else                chk("e_rdata", e_rdata, eq.pop_front());
                chk("h_rdata_while_e", h_rdata, 16'h0);
            end
            if (chk_zero) begin
                zv = {h_gnt, e_gnt, h_rvalid, e_rvalid, ram_en, ram_we, busy,
                      ram_addr, ram_wdata, h_rdata, e_rdata};
                chk("reset_outputs", zv, 59'd0);
            end
            if (chk_busy) chk("busy", busy, exp_busy);
            if (done) begin
                chk("grants_drained", gq.size(), 0);
                chk("h_reads_drained", hq.size(), 0);
                chk("e_reads_drained", eq.size(), 0);
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $finish;
            end
        end
    end

    // One cycle of stimulus plus the hand-computed grant and read-return expectations.
    task automatic cyc(input logic hr, input logic hw, input logic [3:0] ha, input logic [15:0] hd,
                       input logic er, input logic ew, input logic el, input logic [3:0] ea,
                       input logic [15:0] ed, input int g, input logic [15:0] xr, input logic nr);
        gexp_t x;
        @(posedge clk);
        #1;
        chk_zero = 1'b0;
        chk_busy = 1'b0;
        h_req = hr; h_we = hw; h_addr = ha; h_wdata = hd;
        e_req = er; e_we = ew; e_lock = el; e_addr = ea; e_wdata = ed;
        if (g == G_H) begin
            x.eng = 1'b0; x.we = hw; x.addr = ha; x.wdata = hd;
            gq.push_back(x);
            if (!hw && !nr) hq.push_back(xr);
        end else if (g == G_E) begin
            x.eng = 1'b1; x.we = ew; x.addr = ea; x.wdata = ed;
            gq.push_back(x);
            if (!ew && !nr) eq.push_back(xr);
        end
    endtask

    task automatic idle();
        cyc(0, 0, 4'd0, 16'h0, 0, 0, 0, 4'd0, 16'h0, G_N, 16'h0, 0);
    endtask

    // Reset for two cycles with both ports requesting; all outputs must stay 0.
    task automatic do_reset();
        @(posedge clk);
        #1;
        chk_busy = 1'b0;
        rst   = 1'b0;
        h_req = 1'b1; h_we = 1'b0; h_addr = 4'd1; h_wdata = 16'h5555;
        e_req = 1'b1; e_we = 1'b0; e_lock = 1'b1; e_addr = 4'd2; e_wdata = 16'hAAAA;
        chk_zero = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_zero = 1'b0;
        rst   = 1'b1;
        h_req = 1'b0; h_addr = 4'd0; h_wdata = 16'h0;
        e_req = 1'b0; e_lock = 1'b0; e_addr = 4'd0; e_wdata = 16'h0;
    endtask

    initial begin
        rst = 1'b0;
        h_req = 1'b0; h_we = 1'b0; h_addr = 4'd0; h_wdata = 16'h0;
        e_req = 1'b0; e_we = 1'b0; e_lock = 1'b0; e_addr = 4'd0; e_wdata = 16'h0;
        do_reset();

        // 1: host only, write then read back; also preload addr 0..2
        cyc(1, 1, 4'd3, 16'h1234, 0, 0, 0, 4'd0, 16'h0, G_H, 16'h0, 0);
        cyc(1, 0, 4'd3, 16'h0000, 0, 0, 0, 4'd0, 16'h0, G_H, 16'h1234, 0);
        idle();
        chk_busy = 1'b1; exp_busy = 1'b1;
        cyc(1, 1, 4'd0, 16'hA0A0, 0, 0, 0, 4'd0, 16'h0, G_H, 16'h0, 0);
        cyc(1, 1, 4'd1, 16'hB1B1, 0, 0, 0, 4'd0, 16'h0, G_H, 16'h0, 0);
        cyc(1, 1, 4'd2, 16'hC2C2, 0, 0, 0, 4'd0, 16'h0, G_H, 16'h0, 0);
        idle();
        chk_busy = 1'b1; exp_busy = 1'b0;
        idle();

        // 2: both read every cycle from reset -> E,H,E,H
        do_reset();
        cyc(1, 0, 4'd2, 16'h0, 1, 0, 0, 4'd0, 16'h0, G_E, 16'hA0A0, 0);
        cyc(1, 0, 4'd2, 16'h0, 1, 0, 0, 4'd1, 16'h0, G_H, 16'hC2C2, 0);
        cyc(1, 0, 4'd3, 16'h0, 1, 0, 0, 4'd1, 16'h0, G_E, 16'hB1B1, 0);
        cyc(1, 0, 4'd3, 16'h0, 1, 0, 0, 4'd2, 16'h0, G_H, 16'h1234, 0);
        idle();
        idle();

        // 3: locked operand pair while host waits
        do_reset();
        cyc(1, 0, 4'd2, 16'h0, 1, 0, 1, 4'd0, 16'h0, G_E, 16'hA0A0, 0);
        cyc(1, 0, 4'd2, 16'h0, 1, 0, 1, 4'd1, 16'h0, G_E, 16'hB1B1, 0);
        cyc(1, 0, 4'd2, 16'h0, 0, 0, 0, 4'd0, 16'h0, G_H, 16'hC2C2, 0);
        idle();
        idle();

        // 4a: starvation cap with host waiting, then lock re-entry
        do_reset();
        cyc(1, 0, 4'd3, 16'h0, 1, 0, 1, 4'd0, 16'h0, G_E, 16'hA0A0, 0);
        cyc(1, 0, 4'd3, 16'h0, 1, 0, 1, 4'd0, 16'h0, G_E, 16'hA0A0, 0);
        chk_busy = 1'b1; exp_busy = 1'b1;
        cyc(1, 0, 4'd3, 16'h0, 1, 0, 1, 4'd0, 16'h0, G_E, 16'hA0A0, 0);
        cyc(1, 0, 4'd3, 16'h0, 1, 0, 1, 4'd0, 16'h0, G_E, 16'hA0A0, 0);
        cyc(1, 0, 4'd3, 16'h0, 1, 0, 1, 4'd0, 16'h0, G_H, 16'h1234, 0);
        cyc(1, 0, 4'd2, 16'h0, 1, 0, 1, 4'd1, 16'h0, G_E, 16'hB1B1, 0);
        cyc(1, 0, 4'd2, 16'h0, 0, 0, 0, 4'd0, 16'h0, G_H, 16'hC2C2, 0);
        idle();
        idle();

        // 4b: cap reached with no host request -> engine keeps the RAM
        do_reset();
        repeat (5) cyc(0, 0, 4'd0, 16'h0, 1, 0, 1, 4'd1, 16'h0, G_E, 16'hB1B1, 0);
        cyc(1, 0, 4'd3, 16'h0, 1, 0, 1, 4'd1, 16'h0, G_H, 16'h1234, 0);
        cyc(0, 0, 4'd0, 16'h0, 1, 0, 1, 4'd2, 16'h0, G_E, 16'hC2C2, 0);
        idle();
        idle();

        // 5: reset right after an engine read grant drops the return
        cyc(0, 0, 4'd0, 16'h0, 1, 0, 0, 4'd0, 16'h0, G_E, 16'h0, 1);
        do_reset();
        cyc(1, 0, 4'd1, 16'h0, 1, 0, 0, 4'd2, 16'h0, G_E, 16'hC2C2, 0);
        cyc(1, 0, 4'd1, 16'h0, 0, 0, 0, 4'd0, 16'h0, G_H, 16'hB1B1, 0);
        idle();
        idle();

        // 6: engine write then read of the same address
        cyc(0, 0, 4'd0, 16'h0, 1, 1, 0, 4'd5, 16'h00FF, G_E, 16'h0, 0);
        cyc(0, 0, 4'd0, 16'h0, 1, 0, 0, 4'd5, 16'h0000, G_E, 16'h00FF, 0);
        idle();
        idle();
        chk_busy = 1'b1; exp_busy = 1'b0;
        idle();

        done = 1'b1;
    end

endmodule
